read_arbiter_mq: RTL
====================

READ_ARBITER_MQ -- requirements
Module: read_arbiter_mq

Interface
REQ-001 Parameters, one per line (name, default, meaning); SW = max(1,$clog2(S)), MW = max(1,$clog2(M)):
- M, 2, number of masters.
- S, 2, number of slaves.
- ID_W, 1, transaction-ID width.
- DEPTH, 4, ordering-FIFO depth per (master, ID), power of two.
- ADDR_WIDTH, 32, address width.
- SLICE_SIZE, 32'h00010000, bytes per slave address slice.
- PRIO_MODE, 0, 0 = round-robin, 1 = fixed priority (lowest index wins).
REQ-002 Clock and reset:
- clk  in  1  single clock, rising edge.
- clr  in  1  reset, synchronous, active-high.
REQ-003 AR-side ports, per-master fields packed LSB-first by index:
- ar_req  in  M  AR request per master.
- ar_addr  in  M*ADDR_WIDTH  read address.
- ar_id  in  M*ID_W  transaction ID.
- ar_grant  out  M  AR grant, one-hot or zero.
- ar_sel  out  M*SW  decoded target slave.
REQ-004 R-side ports, per-slave fields packed LSB-first by index:
- r_req  in  S  R request per slave.
- r_id  in  S*(MW+ID_W)  {master, transaction ID}.
- r_last  in  S  last beat.
- r_grant  out  S  R grant, one-hot or zero.
- r_sel  out  S*MW  destination master.
REQ-005 Status output: ot_full  out  M*(2**ID_W)  ordering FIFO [m][id] is full, bit index m*2**ID_W+id.

Function
REQ-006 ar_sel[m] SHALL be combinational ar_addr[m]/SLICE_SIZE, saturated to S-1 when the quotient is >= S.
REQ-007 r_sel[s] SHALL be combinational: the master field (upper MW bits) of r_id[s].
REQ-008 One ordering FIFO SHALL exist per (master, ID), DEPTH entries of SW bits, holding the slave index of each granted read in issue order.
REQ-009 AR FSM, states AR_IDLE and AR_GRANT.
REQ-010 AR_IDLE: eligible masters are those with ar_req[m]=1 and FIFO[m][ar_id[m]] not full.
- With any eligible master, the winner is chosen by PRIO_MODE.
- On that edge: go to AR_GRANT, latch winner, push ar_sel[winner] into FIFO[winner][ar_id[winner]].
REQ-011 Round-robin search SHALL start at ar_ptr and wrap modulo M; ar_ptr = winner+1 mod M on leaving AR_GRANT; ar_ptr unchanged in fixed mode.
REQ-012 AR_GRANT: ar_grant[winner]=1, all other grants 0; exactly one push per grant tenure.
- Return to AR_IDLE on the first edge where ar_req[winner]=0.
REQ-013 AR latency: request sampled in AR_IDLE at edge n, ar_grant high from cycle n+1; minimum one idle cycle between tenures.
REQ-014 R FSM, states R_IDLE and R_GRANT.
REQ-015 R_IDLE: slave s is eligible when all of the following hold:
- r_req[s]=1;
- FIFO[r_sel[s]][r_id[s].ID] is not empty;
- its head equals s.
- Winner chosen by PRIO_MODE using a separate pointer r_ptr modulo S.
REQ-016 On the R_IDLE->R_GRANT edge, that FIFO SHALL pop. R_GRANT drives r_grant[winner]=1 and holds until r_last[winner]=1 is sampled, then returns to R_IDLE.
- Round-robin: r_ptr = winner+1 mod S on that return.
REQ-017 A push and a pop on the same FIFO in the same cycle SHALL both take effect; occupancy is unchanged.
REQ-018 Ineligible requests (out-of-order slave, empty FIFO, full FIFO) SHALL stall without error until eligible.
REQ-019 FIFO pointers SHALL wrap modulo DEPTH; occupancy counter is $clog2(DEPTH)+1 bits.

Reset
REQ-020 While clr=1 at an edge: both FSMs go to IDLE, ar_ptr=r_ptr=0, all FIFOs empty; ar_grant=0, r_grant=0, ot_full=0 from the next cycle.
REQ-021 clr asserted during AR_GRANT or R_GRANT SHALL drop the grant after that edge and discard all outstanding ordering state.

Verification
REQ-022 M=2, S=2, round-robin; both masters request ID 0, address 0x0001_0004 -> grant m0 first (ar_sel=1), then m1 after m0 drops ar_req.
REQ-023 DEPTH=2; m0 issues two ID-0 reads without responses -> ot_full[0]=1; a third request stalls; one R completion -> third grant follows.
REQ-024 m0 issues ID 0 to slave 1, then ID 0 to slave 0; slave 0 responds first -> no r_grant until slave 1 completes with r_last.
REQ-025 PRIO_MODE=1, both slaves eligible repeatedly -> slave 0 always wins.
REQ-026 Push and pop on the same FIFO in one cycle at occupancy 1 -> occupancy stays 1, head advances.
REQ-027 clr pulsed mid-R burst -> r_grant=0 next cycle, ot_full=0, subsequent responses stall until new AR grants.

Source files
------------

// File: rtl/read_arbiter_mq.sv
// read_arbiter_mq: AR/R arbiter that keeps per-(master, ID) ordering FIFOs so
// read responses are granted only in the order their requests were issued.
module read_arbiter_mq #(
  parameter int          M          = 2,
  parameter int          S          = 2,
  parameter int          ID_W       = 1,
  parameter int          DEPTH      = 4,
  parameter int          ADDR_WIDTH = 32,
  parameter logic [31:0] SLICE_SIZE = 32'h00010000,
  parameter bit          PRIO_MODE  = 1'b0,
  localparam int         SW         = (S > 1) ? $clog2(S) : 1,
  localparam int         MW         = (M > 1) ? $clog2(M) : 1
) (
  input  logic                      clk,
  input  logic                      clr,
  input  logic [M-1:0]              ar_req,
  input  logic [M*ADDR_WIDTH-1:0]   ar_addr,
  input  logic [M*ID_W-1:0]         ar_id,
  output logic [M-1:0]              ar_grant,
  output logic [M*SW-1:0]           ar_sel,
  input  logic [S-1:0]              r_req,
  input  logic [S*(MW+ID_W)-1:0]    r_id,
  input  logic [S-1:0]              r_last,
  output logic [S-1:0]              r_grant,
  output logic [S*MW-1:0]           r_sel,
  output logic [M*(2**ID_W)-1:0]    ot_full
);
  localparam int NI = 2 ** ID_W;
  localparam int NQ = M * NI;
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [ADDR_WIDTH-1:0] SLICE = ADDR_WIDTH'(SLICE_SIZE);

  typedef enum logic {AR_IDLE, AR_GRANT} ar_st_t;
  typedef enum logic {R_IDLE, R_GRANT} r_st_t;

  logic [SW-1:0] r_mem [NQ][DEPTH];
  logic [PW-1:0] r_wp  [NQ];
  logic [PW-1:0] r_rp  [NQ];
  logic [CW-1:0] r_cnt [NQ];

  ar_st_t        r_ar_st;
  r_st_t         r_r_st;
  logic [MW-1:0] r_ar_win, r_ar_ptr;
  logic [SW-1:0] r_r_win, r_r_ptr;

  logic [M-1:0]  w_ar_elig;
  int            w_ar_q [M];
  logic          w_ar_any;
  logic [MW-1:0] w_ar_w;
  logic [S-1:0]  w_r_elig;
  int            w_r_q [S];
  logic          w_r_any;
  logic [SW-1:0] w_r_w;
  logic          w_push, w_pop;
  logic [SW-1:0] w_push_d;
  logic [NQ-1:0] w_pu, w_po;

  // Address decode saturates so out-of-range addresses land on the last slave.
  for (genvar i = 0; i < M; i++) begin : g_ar
    logic [ADDR_WIDTH-1:0] w_q;
    assign w_q = ar_addr[i*ADDR_WIDTH +: ADDR_WIDTH] / SLICE;
    assign ar_sel[i*SW +: SW] = (w_q >= ADDR_WIDTH'(S)) ? SW'(S - 1) : w_q[SW-1:0];
  end

  for (genvar i = 0; i < S; i++) begin : g_rs
    assign r_sel[i*MW +: MW] = r_id[i*(MW+ID_W) + ID_W +: MW];
  end

  for (genvar i = 0; i < NQ; i++) begin : g_full
    assign ot_full[i] = (r_cnt[i] == CW'(DEPTH));
  end

  always_comb begin
    w_ar_elig = '0;
    for (int m = 0; m < M; m++) begin
      w_ar_q[m]    = m * NI + int'(ar_id[m*ID_W +: ID_W]);
      w_ar_elig[m] = ar_req[m] && !ot_full[w_ar_q[m]];
    end
    w_ar_any = 1'b0;
    w_ar_w   = '0;
    for (int k = 0; k < M; k++) begin
      if (!w_ar_any && w_ar_elig[((PRIO_MODE ? 0 : int'(r_ar_ptr)) + k) % M]) begin
        w_ar_any = 1'b1;
        w_ar_w   = MW'(((PRIO_MODE ? 0 : int'(r_ar_ptr)) + k) % M);
      end
    end
  end

  // A slave may respond only if it is the oldest outstanding target for that (master, ID).
  always_comb begin
    w_r_elig = '0;
    for (int s = 0; s < S; s++) begin
      w_r_q[s]    = (int'(r_sel[s*MW +: MW]) < M)
                  ? int'(r_sel[s*MW +: MW]) * NI + int'(r_id[s*(MW+ID_W) +: ID_W]) : 0;
      w_r_elig[s] = r_req[s] && (int'(r_sel[s*MW +: MW]) < M) && (r_cnt[w_r_q[s]] != '0)
                  && (r_mem[w_r_q[s]][r_rp[w_r_q[s]]] == SW'(s));
    end
    w_r_any = 1'b0;
    w_r_w   = '0;
    for (int k = 0; k < S; k++) begin
      if (!w_r_any && w_r_elig[((PRIO_MODE ? 0 : int'(r_r_ptr)) + k) % S]) begin
        w_r_any = 1'b1;
        w_r_w   = SW'(((PRIO_MODE ? 0 : int'(r_r_ptr)) + k) % S);
      end
    end
  end

  always_comb begin
    w_push   = (r_ar_st == AR_IDLE) && w_ar_any;
    w_pop    = (r_r_st == R_IDLE) && w_r_any;
    w_push_d = ar_sel[int'(w_ar_w)*SW +: SW];
    w_pu     = '0;
    w_po     = '0;
    for (int q = 0; q < NQ; q++) begin
      w_pu[q] = w_push && (w_ar_q[w_ar_w] == q);
      w_po[q] = w_pop && (w_r_q[w_r_w] == q);
    end
  end

  always_ff @(posedge clk) begin
    for (int q = 0; q < NQ; q++) begin
      if (clr) begin
        r_wp[q]  <= '0;
        r_rp[q]  <= '0;
        r_cnt[q] <= '0;
      end else begin
        if (w_pu[q]) begin
          r_mem[q][r_wp[q]] <= w_push_d;
          r_wp[q]           <= (int'(r_wp[q]) == DEPTH - 1) ? '0 : r_wp[q] + 1'b1;
        end
        if (w_po[q])
          r_rp[q] <= (int'(r_rp[q]) == DEPTH - 1) ? '0 : r_rp[q] + 1'b1;
        r_cnt[q] <= r_cnt[q] + CW'(w_pu[q]) - CW'(w_po[q]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      r_ar_st  <= AR_IDLE;
      r_ar_win <= '0;
      r_ar_ptr <= '0;
      ar_grant <= '0;
    end else if (r_ar_st == AR_IDLE) begin
      if (w_ar_any) begin
        r_ar_st  <= AR_GRANT;
        r_ar_win <= w_ar_w;
        ar_grant <= M'(1) << w_ar_w;
      end
    end else if (!ar_req[r_ar_win]) begin
      r_ar_st  <= AR_IDLE;
      ar_grant <= '0;
      if (!PRIO_MODE)
        r_ar_ptr <= (int'(r_ar_win) == M - 1) ? '0 : r_ar_win + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      r_r_st  <= R_IDLE;
      r_r_win <= '0;
      r_r_ptr <= '0;
      r_grant <= '0;
    end else if (r_r_st == R_IDLE) begin
      if (w_r_any) begin
        r_r_st  <= R_GRANT;
        r_r_win <= w_r_w;
        r_grant <= S'(1) << w_r_w;
      end
    end else if (r_last[r_r_win]) begin
      r_r_st  <= R_IDLE;
      r_grant <= '0;
      if (!PRIO_MODE)
        r_r_ptr <= (int'(r_r_win) == S - 1) ? '0 : r_r_win + 1'b1;
    end
  end
endmodule
